// File: rtl/part_374_pipe.sv
// Clock-enabled WIDTH x DEPTH register pipeline with per-stage valid bits, flush, occupancy count and a tri-state output.
// Optional per-stage parity with fault injection, built when PART374_PARITY_EN is defined.
module part_374_pipe #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    parameter int OCCW  = $clog2(DEPTH + 1)
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [WIDTH-1:0] D,
    input  logic             LOAD,
    input  logic             CE,
    input  logic             FLUSH,
    input  logic             OENB_N,
`ifdef PART374_PARITY_EN
    input  logic             PFLIP,
    output logic             PERR,
`endif
    output logic [WIDTH-1:0] Q,
    output logic             QVALID,
    output logic [OCCW-1:0]  OCC
);

    logic [DEPTH-1:0][WIDTH-1:0] r_data;
    logic [DEPTH-1:0]            r_vld;
    logic [OCCW-1:0]             r_occ;

    // Data keeps shifting under invalid valid bits; FLUSH only clears the valids.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_data <= '0;
            r_vld  <= '0;
            r_occ  <= '0;
        end else if (FLUSH) begin
            r_vld  <= '0;
            r_occ  <= '0;
        end else if (CE) begin
            r_data[0] <= D;
            r_vld[0]  <= LOAD;
            for (int i = 1; i < DEPTH; i++) begin
                r_data[i] <= r_data[i-1];
                r_vld[i]  <= r_vld[i-1];
            end
            r_occ <= r_occ + OCCW'(LOAD) - OCCW'(r_vld[DEPTH-1]);
        end
    end

`ifdef PART374_PARITY_EN
    logic [DEPTH-1:0] r_par;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_par <= '0;
        end else if (!FLUSH && CE) begin
            r_par[0] <= (^D) ^ PFLIP;
            for (int i = 1; i < DEPTH; i++) begin
                r_par[i] <= r_par[i-1];
            end
        end
    end

    assign PERR = r_vld[DEPTH-1] & ((^r_data[DEPTH-1]) != r_par[DEPTH-1]);
`endif

    assign Q      = OENB_N ? {WIDTH{1'bz}} : r_data[DEPTH-1];
    assign QVALID = r_vld[DEPTH-1];
    assign OCC    = r_occ;

endmodule
